// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package mips_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int DIV_CYCLES = MD_WIDTH;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_DIV   = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_e;

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring-division iteration
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // quo doubles as the dividend shift register: its MSB feeds the partial
  // remainder while the new quotient bit enters at the LSB.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO registers with single-cycle multiply and iterative divide
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int              CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem_q, quo_q, divisor_q;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               quo_neg, rem_neg, div_zero, done_q;

  logic               is_sdiv;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand conditioning: magnitudes for signed divide, full-width products for multiply.
  // The low 2*WIDTH bits of a sign-extended product equal the signed product.
  always_comb begin
    is_sdiv = (Op == MD_OP_DIV);
    a_abs   = (is_sdiv && A[WIDTH-1]) ? -A : A;
    b_abs   = (is_sdiv && B[WIDTH-1]) ? -B : B;
    prod_s  = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    quo_fix = div_zero ? '1 : (quo_neg ? -quo_q : quo_q);
    rem_fix = rem_neg ? -rem_q : rem_q;
  end

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Issue, divide iteration and sign fixup; Reset beats Cancel beats Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      quo_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      div_zero  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (Start && !Cancel) begin
            case (Op)
              MD_OP_MULT:  begin {hi_q, lo_q} <= prod_s; done_q <= 1'b1; end
              MD_OP_MULTU: begin {hi_q, lo_q} <= prod_u; done_q <= 1'b1; end
              MD_OP_MTHI:  begin hi_q <= A; done_q <= 1'b1; end
              MD_OP_MTLO:  begin lo_q <= A; done_q <= 1'b1; end
              MD_OP_DIV, MD_OP_DIVU: begin
                rem_q     <= '0;
                quo_q     <= a_abs;
                divisor_q <= b_abs;
                quo_neg   <= is_sdiv && (A[WIDTH-1] ^ B[WIDTH-1]);
                rem_neg   <= is_sdiv && A[WIDTH-1];
                div_zero  <= (B == '0);
                cnt       <= '0;
                state     <= MD_DIV;
              end
              default: ;
            endcase
          end
        end
        MD_DIV: begin
          if (Cancel) begin
            state <= MD_IDLE;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= MD_FIXUP;
          end
        end
        MD_FIXUP: begin
          if (!Cancel) begin
            lo_q   <= quo_fix;
            hi_q   <= rem_fix;
            done_q <= 1'b1;
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign Busy = (state != MD_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Cancel = 1'b0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int compared = 0;
  int mismatched = 0;
  int illegal_starts = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Cancel(Cancel), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  // Issue while the unit is busy is a hazard-unit violation; tallied here.
  always @(posedge Clk) if (!Reset && Start && Busy) illegal_starts++;

  // Architectural reference: updates m_hi/m_lo, returns expected Done and busy length.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic exp_done, output int exp_busy);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    exp_done = 1'b1;
    exp_busy = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2, 3'd3: begin
        exp_busy = 33;
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb; qv = q; rv = r;
          m_lo = qv[31:0]; m_hi = rv[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: exp_done = 1'b0;
    endcase
  endfunction

  // Drives one issue and follows it to completion; reports observed outputs.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output logic early_done, output logic done_obs);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    busy_cyc = 0; early_done = 1'b0;
    while (Busy && busy_cyc < 200) begin
      busy_cyc++;
      if (Done) early_done = 1'b1;
      @(negedge Clk);
    end
    done_obs = Done;
  endtask

  task automatic test_reset;
    int bc; logic ed, dn, ed_exp; int bexp;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    compared += 4;
    if (Hi !== 32'd0) begin mismatched++; $display("FAIL reset_hi got %h want 0", Hi); end
    if (Lo !== 32'd0) begin mismatched++; $display("FAIL reset_lo got %h want 0", Lo); end
    if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", Busy); end
    if (Done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", Done); end
    run_op(3'd4, 32'h1234_5678, 32'd0, bc, ed, dn);
    model(3'd4, 32'h1234_5678, 32'd0, ed_exp, bexp);
    compared += 2;
    if (Hi !== 32'h1234_5678) begin mismatched++; $display("FAIL mthi_hi got %h want 12345678", Hi); end
    if (dn !== 1'b1) begin mismatched++; $display("FAIL mthi_done got %b want 1", dn); end
  endtask

  task automatic test_mult;
    int bc; logic ed, dn, de; int be;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, bc, ed, dn);
    model(3'd0, 32'hFFFF_FFFE, 32'd3, de, be);
    compared += 3;
    if (Hi !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mult_hi got %h want ffffffff", Hi); end
    if (Lo !== 32'hFFFF_FFFA) begin mismatched++; $display("FAIL mult_lo got %h want fffffffa", Lo); end
    if (dn !== 1'b1) begin mismatched++; $display("FAIL mult_done got %b want 1", dn); end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, bc, ed, dn);
    model(3'd1, 32'hFFFF_FFFE, 32'd3, de, be);
    compared += 2;
    if (Hi !== 32'h2) begin mismatched++; $display("FAIL multu_hi got %h want 2", Hi); end
    if (Lo !== 32'hFFFF_FFFA) begin mismatched++; $display("FAIL multu_lo got %h want fffffffa", Lo); end
  endtask

  task automatic test_div;
    int bc; logic ed, dn, de; int be;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, ed, dn);
    model(3'd2, 32'hFFFF_FFF9, 32'd2, de, be);
    compared += 5;
    if (bc != 33) begin mismatched++; $display("FAIL div_busy_cycles got %0d want 33", bc); end
    if (dn !== 1'b1 || ed !== 1'b0) begin mismatched++; $display("FAIL div_done_timing got done=%b early=%b want 1/0", dn, ed); end
    if (Lo !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_lo got %h want fffffffd", Lo); end
    if (Hi !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL div_hi got %h want ffffffff", Hi); end
    if (Lo !== m_lo) begin mismatched++; $display("FAIL div_model_lo got %h want %h", Lo, m_lo); end
    run_op(3'd3, 32'd100, 32'd7, bc, ed, dn);
    model(3'd3, 32'd100, 32'd7, de, be);
    compared += 2;
    if (Lo !== 32'd14) begin mismatched++; $display("FAIL divu_lo got %h want e", Lo); end
    if (Hi !== 32'd2) begin mismatched++; $display("FAIL divu_hi got %h want 2", Hi); end
  endtask

  task automatic test_div_edges;
    int bc; logic ed, dn, de; int be;
    run_op(3'd3, 32'd5, 32'd0, bc, ed, dn);
    model(3'd3, 32'd5, 32'd0, de, be);
    compared += 3;
    if (Lo !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL divzero_lo got %h want ffffffff", Lo); end
    if (Hi !== 32'd5) begin mismatched++; $display("FAIL divzero_hi got %h want 5", Hi); end
    if (bc != 33) begin mismatched++; $display("FAIL divzero_busy got %0d want 33", bc); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, ed, dn);
    model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, de, be);
    compared += 2;
    if (Lo !== 32'h8000_0000) begin mismatched++; $display("FAIL divovf_lo got %h want 80000000", Lo); end
    if (Hi !== 32'd0) begin mismatched++; $display("FAIL divovf_hi got %h want 0", Hi); end
  endtask

  task automatic test_random;
    int bc, be; logic ed, dn, de;
    logic [2:0] op; logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (i == 7) begin op = 3'd2; b = 32'd0; a = 32'hF000_0001; end
      run_op(op, a, b, bc, ed, dn);
      model(op, a, b, de, be);
      compared += 4;
      if (Hi !== m_hi) begin mismatched++; $display("FAIL rand_hi op=%0d a=%h b=%h got %h want %h", op, a, b, Hi, m_hi); end
      if (Lo !== m_lo) begin mismatched++; $display("FAIL rand_lo op=%0d a=%h b=%h got %h want %h", op, a, b, Lo, m_lo); end
      if (dn !== de) begin mismatched++; $display("FAIL rand_done op=%0d got %b want %b", op, dn, de); end
      if (bc != be) begin mismatched++; $display("FAIL rand_busy op=%0d got %0d want %0d", op, bc, be); end
    end
  endtask

  task automatic test_cancel;
    logic [31:0] hi0, lo0;
    hi0 = m_hi; lo0 = m_lo;
    @(negedge Clk); Start = 1'b1; Op = 3'd2; A = 32'd1000; B = 32'd3;
    @(negedge Clk); Start = 1'b0;
    repeat (10) @(negedge Clk);
    Cancel = 1'b1;
    @(negedge Clk); Cancel = 1'b0;
    compared += 4;
    if (Busy !== 1'b0) begin mismatched++; $display("FAIL cancel_busy got %b want 0", Busy); end
    if (Done !== 1'b0) begin mismatched++; $display("FAIL cancel_done got %b want 0", Done); end
    if (Hi !== hi0) begin mismatched++; $display("FAIL cancel_hi got %h want %h", Hi, hi0); end
    if (Lo !== lo0) begin mismatched++; $display("FAIL cancel_lo got %h want %h", Lo, lo0); end
    repeat (3) @(negedge Clk);
    compared += 1;
    if (Done !== 1'b0 || Lo !== lo0) begin mismatched++; $display("FAIL cancel_late got done=%b lo=%h want 0/%h", Done, Lo, lo0); end
    @(negedge Clk); Start = 1'b1; Op = 3'd3; A = 32'd77; B = 32'd5;
    @(negedge Clk); Start = 1'b0;
    repeat (20) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    compared += 3;
    if (Busy !== 1'b0) begin mismatched++; $display("FAIL rstdiv_busy got %b want 0", Busy); end
    if (Hi !== 32'd0) begin mismatched++; $display("FAIL rstdiv_hi got %h want 0", Hi); end
    if (Lo !== 32'd0) begin mismatched++; $display("FAIL rstdiv_lo got %h want 0", Lo); end
  endtask

  task automatic test_start_while_busy;
    int n0, bc, be; logic de, ed;
    n0 = illegal_starts;
    @(negedge Clk); Start = 1'b1; Op = 3'd2; A = 32'hFFFF_FF9C; B = 32'd9;
    @(negedge Clk); Start = 1'b0;
    model(3'd2, 32'hFFFF_FF9C, 32'd9, de, be);
    repeat (5) @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'h1111_1111; B = 32'h2222_2222;
    @(negedge Clk); Start = 1'b0;
    bc = 0;
    while (Busy && bc < 200) begin bc++; @(negedge Clk); end
    compared += 4;
    if (Hi !== m_hi) begin mismatched++; $display("FAIL busy_start_hi got %h want %h", Hi, m_hi); end
    if (Lo !== m_lo) begin mismatched++; $display("FAIL busy_start_lo got %h want %h", Lo, m_lo); end
    if (Done !== 1'b1) begin mismatched++; $display("FAIL busy_start_done got %b want 1", Done); end
    if (illegal_starts != n0 + 1) begin mismatched++; $display("FAIL busy_start_flag got %0d want %0d", illegal_starts - n0, 1); end
    @(negedge Clk); Start = 1'b1; Cancel = 1'b1; Op = 3'd4; A = ~m_hi;
    @(negedge Clk); Start = 1'b0; Cancel = 1'b0;
    compared += 2;
    if (Hi !== m_hi) begin mismatched++; $display("FAIL idle_cancel_hi got %h want %h", Hi, m_hi); end
    if (Done !== 1'b0) begin mismatched++; $display("FAIL idle_cancel_done got %b want 0", Done); end
    ed = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edges();
    test_random();
    test_cancel();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
